sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter_if.sv | 56 +++++
 rtl/sram_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the two byte requesters (core and bridge loader),
// the arbiter, and the byte RAM controller.
// The arbiter sits on the slave modport; requesters and the RAM
// controller together sit on the master modport.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 26
);

    // Requester 0: core
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [7:0]        r0_wdata;
    logic              r0_ack;
    logic [7:0]        r0_rdata;

    // Requester 1: bridge loader
    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [7:0]        r1_wdata;
    logic              r1_ack;
    logic [7:0]        r1_rdata;

    // Byte RAM controller side
    logic              word_rd;
    logic              word_wr;
    logic [ADDR_W-1:0] word_addr;
    logic [7:0]        word_data;
    logic [7:0]        word_q;
    logic              word_busy;

    // Status
    logic              timeout_err;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_ack, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_ack, r1_rdata,
        output word_rd, word_wr, word_addr, word_data,
        input  word_q, word_busy,
        output timeout_err
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_ack, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_ack, r1_rdata,
        input  word_rd, word_wr, word_addr, word_data,
        output word_q, word_busy,
        input  timeout_err
    );

endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester byte arbiter in front of a byte RAM controller.
// One access at a time: grant in IDLE, a fixed GAP cycle, then WAIT for
// the controller to drop busy (or abort after TIMEOUT busy cycles).
// Ties go round robin; a requester whose ack is high this cycle is left
// out of arbitration so a still-held request is not granted twice.
// All outputs come straight from flops.
module sram_port_arbiter #(
    parameter int ADDR_W  = 26,
    parameter int TIMEOUT = 1023
) (
    input logic                clk_sys,
    input logic                reset_l,
    sram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_WAIT
    } state_t;

    // Abort fires on the WAIT edge where the busy counter would reach TIMEOUT.
    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT - 1);

    state_t            state_q;
    logic [9:0]        waitCnt_q;
    logic              lastGrant_q;
    logic              curSel_q;
    logic              curWe_q;

    logic              wordRd_q;
    logic              wordWr_q;
    logic [ADDR_W-1:0] wordAddr_q;
    logic [7:0]        wordData_q;
    logic              ack0_q;
    logic              ack1_q;
    logic [7:0]        rdata0_q;
    logic [7:0]        rdata1_q;
    logic              timeoutErr_q;

    logic              elig0;
    logic              elig1;
    logic              canGrant;
    logic              pickSel;
    logic              pickWe;
    logic [ADDR_W-1:0] pickAddr;
    logic [7:0]        pickData;
    logic              finishNow;
    logic              timedOut;
    logic [7:0]        finishData;

    // Arbitration and completion decisions for the current cycle.
    always_comb begin
        elig0      = bus.r0_req & ~ack0_q;
        elig1      = bus.r1_req & ~ack1_q;
        canGrant   = (state_q == ST_IDLE) & ~bus.word_busy & (elig0 | elig1);

        if (elig0 && elig1) begin
            pickSel = ~lastGrant_q;
        end else begin
            pickSel = elig1;
        end

        if (pickSel) begin
            pickWe   = bus.r1_we;
            pickAddr = bus.r1_addr;
            pickData = bus.r1_wdata;
        end else begin
            pickWe   = bus.r0_we;
            pickAddr = bus.r0_addr;
            pickData = bus.r0_wdata;
        end

        timedOut   = (state_q == ST_WAIT) & bus.word_busy & (waitCnt_q == TIMEOUT_LAST);
        finishNow  = (state_q == ST_WAIT) & (~bus.word_busy | timedOut);
        finishData = timedOut ? 8'hFF : bus.word_q;
    end

    // Access FSM together with every registered output.
    always_ff @(posedge clk_sys or negedge reset_l) begin
        if (!reset_l) begin
            state_q      <= ST_IDLE;
            waitCnt_q    <= '0;
            lastGrant_q  <= 1'b1;
            curSel_q     <= 1'b0;
            curWe_q      <= 1'b0;
            wordRd_q     <= 1'b0;
            wordWr_q     <= 1'b0;
            wordAddr_q   <= '0;
            wordData_q   <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            wordRd_q <= 1'b0;
            wordWr_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (canGrant) begin
                        wordAddr_q  <= pickAddr;
                        wordData_q  <= pickData;
                        wordWr_q    <= pickWe;
                        wordRd_q    <= ~pickWe;
                        curSel_q    <= pickSel;
                        curWe_q     <= pickWe;
                        lastGrant_q <= pickSel;
                        state_q     <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    waitCnt_q <= '0;
                    state_q   <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (finishNow) begin
                        if (curSel_q) begin
                            ack1_q <= 1'b1;
                        end else begin
                            ack0_q <= 1'b1;
                        end
                        if (!curWe_q) begin
                            if (curSel_q) begin
                                rdata1_q <= finishData;
                            end else begin
                                rdata0_q <= finishData;
                            end
                        end
                        if (timedOut) begin
                            timeoutErr_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end else begin
                        waitCnt_q <= waitCnt_q + 10'd1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.word_rd     = wordRd_q;
    assign bus.word_wr     = wordWr_q;
    assign bus.word_addr   = wordAddr_q;
    assign bus.word_data   = wordData_q;
    assign bus.r0_ack      = ack0_q;
    assign bus.r1_ack      = ack1_q;
    assign bus.r0_rdata    = rdata0_q;
    assign bus.r1_rdata    = rdata1_q;
    assign bus.timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter: a per-cycle vector table for
// the plain read / busy-gated write, and hand-written sequences for
// timeout, input churn, contention and reset in the middle of WAIT.
module tb_sram_port_arbiter;

    localparam int ADDR_W  = 26;
    localparam int TIMEOUT = 1023;

    logic clk_sys;
    logic reset_l;

    int nChecks = 0;
    int nFails  = 0;

    sram_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    sram_port_arbiter #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_sys(clk_sys),
        .reset_l(reset_l),
        .bus    (bus.slave)
    );

    // 100 MHz system clock.
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Hard stop in case something hangs.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        string             name;
        logic              r0Req;
        logic              r0We;
        logic [ADDR_W-1:0] r0Addr;
        logic [7:0]        r0Wdata;
        logic              r1Req;
        logic              r1We;
        logic [ADDR_W-1:0] r1Addr;
        logic [7:0]        r1Wdata;
        logic              busy;
        logic [7:0]        wordQ;
        logic              expRd;
        logic              expWr;
        logic [ADDR_W-1:0] expAddr;
        logic [7:0]        expData;
        logic              expAck0;
        logic              expAck1;
        logic [7:0]        expRdata0;
        logic [7:0]        expRdata1;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic driveIdle();
        bus.r0_req    = 1'b0;
        bus.r0_we     = 1'b0;
        bus.r0_addr   = '0;
        bus.r0_wdata  = '0;
        bus.r1_req    = 1'b0;
        bus.r1_we     = 1'b0;
        bus.r1_addr   = '0;
        bus.r1_wdata  = '0;
        bus.word_busy = 1'b0;
        bus.word_q    = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.r0_req    = v.r0Req;
        bus.r0_we     = v.r0We;
        bus.r0_addr   = v.r0Addr;
        bus.r0_wdata  = v.r0Wdata;
        bus.r1_req    = v.r1Req;
        bus.r1_we     = v.r1We;
        bus.r1_addr   = v.r1Addr;
        bus.r1_wdata  = v.r1Wdata;
        bus.word_busy = v.busy;
        bus.word_q    = v.wordQ;
    endtask

    function automatic void addVec(
        input string name,
        input logic r0Req, input logic r0We, input logic [ADDR_W-1:0] r0Addr, input logic [7:0] r0Wdata,
        input logic r1Req, input logic r1We, input logic [ADDR_W-1:0] r1Addr, input logic [7:0] r1Wdata,
        input logic busy, input logic [7:0] wordQ,
        input logic expRd, input logic expWr, input logic [ADDR_W-1:0] expAddr, input logic [7:0] expData,
        input logic expAck0, input logic expAck1, input logic [7:0] expRdata0, input logic [7:0] expRdata1);
        vec_t v;
        v.name = name;
        v.r0Req = r0Req;   v.r0We = r0We;   v.r0Addr = r0Addr;   v.r0Wdata = r0Wdata;
        v.r1Req = r1Req;   v.r1We = r1We;   v.r1Addr = r1Addr;   v.r1Wdata = r1Wdata;
        v.busy = busy;     v.wordQ = wordQ;
        v.expRd = expRd;   v.expWr = expWr; v.expAddr = expAddr; v.expData = expData;
        v.expAck0 = expAck0; v.expAck1 = expAck1;
        v.expRdata0 = expRdata0; v.expRdata1 = expRdata1;
        vecs.push_back(v);
    endfunction

    // The two strobes must never be high together.
    always @(negedge clk_sys) begin
        if (reset_l === 1'b1) begin
            checkOutput("strobeExclusive", 32'(bus.word_rd & bus.word_wr), 32'd0);
        end
    end

    initial begin
        int cycles;
        int nStrobe;
        int nAck0;
        int nAck1;
        logic [12:0] strobeMask;
        logic [12:0] ack0Mask;
        logic [12:0] ack1Mask;
        logic [12:0] addr10Mask;

        // ---------- vector table ----------
        // Single read by r0 at 0x0000123; controller busy for 4 cycles after the strobe.
        addVec("read.grant", 1,0,26'h0000123,8'h00, 0,0,26'h0,8'h00, 0,8'h00, 1,0,26'h0000123,8'h00, 0,0,8'h00,8'h00);
        addVec("read.gap",   1,0,26'h0000123,8'h00, 0,0,26'h0,8'h00, 1,8'h00, 0,0,26'h0000123,8'h00, 0,0,8'h00,8'h00);
        addVec("read.wait1", 1,0,26'h0000123,8'h00, 0,0,26'h0,8'h00, 1,8'h00, 0,0,26'h0000123,8'h00, 0,0,8'h00,8'h00);
        addVec("read.wait2", 1,0,26'h0000123,8'h00, 0,0,26'h0,8'h00, 1,8'h00, 0,0,26'h0000123,8'h00, 0,0,8'h00,8'h00);
        addVec("read.wait3", 1,0,26'h0000123,8'h00, 0,0,26'h0,8'h00, 1,8'h00, 0,0,26'h0000123,8'h00, 0,0,8'h00,8'h00);
        addVec("read.ack",   1,0,26'h0000123,8'h00, 0,0,26'h0,8'h00, 0,8'h5A, 0,0,26'h0000123,8'h00, 1,0,8'h5A,8'h00);
        addVec("read.drop",  0,0,26'h0000123,8'h00, 0,0,26'h0,8'h00, 0,8'h00, 0,0,26'h0000123,8'h00, 0,0,8'h5A,8'h00);
        // r1 write 0xA5 to 0x3FFFFFF held off by busy for 10 idle cycles.
        for (int i = 0; i < 10; i++) begin
            addVec($sformatf("gate.busy%0d", i), 0,0,26'h0,8'h00, 1,1,26'h3FFFFFF,8'hA5, 1,8'h00,
                   0,0,26'h0000123,8'h00, 0,0,8'h5A,8'h00);
        end
        addVec("gate.grant", 0,0,26'h0,8'h00, 1,1,26'h3FFFFFF,8'hA5, 0,8'h00, 0,1,26'h3FFFFFF,8'hA5, 0,0,8'h5A,8'h00);
        addVec("gate.gap",   0,0,26'h0,8'h00, 1,1,26'h3FFFFFF,8'hA5, 0,8'h00, 0,0,26'h3FFFFFF,8'hA5, 0,0,8'h5A,8'h00);
        addVec("gate.ack",   0,0,26'h0,8'h00, 1,1,26'h3FFFFFF,8'hA5, 0,8'h77, 0,0,26'h3FFFFFF,8'hA5, 0,1,8'h5A,8'h00);
        addVec("gate.drop",  0,0,26'h0,8'h00, 0,1,26'h3FFFFFF,8'hA5, 0,8'h00, 0,0,26'h3FFFFFF,8'hA5, 0,0,8'h5A,8'h00);

        // ---------- reset state ----------
        driveIdle();
        reset_l = 1'b0;
        repeat (3) tick();
        checkOutput("reset.word_rd",     32'(bus.word_rd),     32'd0);
        checkOutput("reset.word_wr",     32'(bus.word_wr),     32'd0);
        checkOutput("reset.word_addr",   32'(bus.word_addr),   32'd0);
        checkOutput("reset.word_data",   32'(bus.word_data),   32'd0);
        checkOutput("reset.r0_ack",      32'(bus.r0_ack),      32'd0);
        checkOutput("reset.r1_ack",      32'(bus.r1_ack),      32'd0);
        checkOutput("reset.r0_rdata",    32'(bus.r0_rdata),    32'd0);
        checkOutput("reset.r1_rdata",    32'(bus.r1_rdata),    32'd0);
        checkOutput("reset.timeout_err", 32'(bus.timeout_err), 32'd0);
        reset_l = 1'b1;

        // ---------- table-driven part ----------
        foreach (vecs[k]) begin
            applyStimulus(vecs[k]);
            tick();
            checkOutput({vecs[k].name, ".word_rd"},   32'(bus.word_rd),     32'(vecs[k].expRd));
            checkOutput({vecs[k].name, ".word_wr"},   32'(bus.word_wr),     32'(vecs[k].expWr));
            checkOutput({vecs[k].name, ".word_addr"}, 32'(bus.word_addr),   32'(vecs[k].expAddr));
            checkOutput({vecs[k].name, ".word_data"}, 32'(bus.word_data),   32'(vecs[k].expData));
            checkOutput({vecs[k].name, ".r0_ack"},    32'(bus.r0_ack),      32'(vecs[k].expAck0));
            checkOutput({vecs[k].name, ".r1_ack"},    32'(bus.r1_ack),      32'(vecs[k].expAck1));
            checkOutput({vecs[k].name, ".r0_rdata"},  32'(bus.r0_rdata),    32'(vecs[k].expRdata0));
            checkOutput({vecs[k].name, ".r1_rdata"},  32'(bus.r1_rdata),    32'(vecs[k].expRdata1));
            checkOutput({vecs[k].name, ".err"},       32'(bus.timeout_err), 32'd0);
        end

        // ---------- timeout: busy stuck high after an r0 read ----------
        driveIdle();
        bus.r0_req  = 1'b1;
        bus.r0_addr = 26'h0000200;
        tick();
        checkOutput("timeout.strobe", 32'(bus.word_rd), 32'd1);
        bus.word_busy = 1'b1;
        // WAIT starts the cycle after the strobe; the abort ack lands TIMEOUT cycles later.
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (bus.r0_ack !== 1'b1 && cycles < 2000);
        checkOutput("timeout.latency", 32'(cycles), 32'(TIMEOUT + 1));
        checkOutput("timeout.r0_rdata", 32'(bus.r0_rdata),    32'hFF);
        checkOutput("timeout.err",      32'(bus.timeout_err), 32'd1);
        bus.r0_req    = 1'b0;
        bus.word_busy = 1'b0;
        tick();
        checkOutput("timeout.ackOnce",   32'(bus.r0_ack),      32'd0);
        checkOutput("timeout.errSticky", 32'(bus.timeout_err), 32'd1);

        // ---------- input churn right after an r1 write grant ----------
        bus.r1_req   = 1'b1;
        bus.r1_we    = 1'b1;
        bus.r1_addr  = 26'h0000055;
        bus.r1_wdata = 8'h11;
        tick();
        checkOutput("churn.word_wr",   32'(bus.word_wr),   32'd1);
        checkOutput("churn.word_addr", 32'(bus.word_addr), 32'h55);
        checkOutput("churn.word_data", 32'(bus.word_data), 32'h11);
        bus.r1_addr  = 26'h0000066;
        bus.r1_wdata = 8'h22;
        bus.r1_req   = 1'b0;
        nStrobe = 0;
        nAck1   = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            nStrobe += int'(bus.word_rd) + int'(bus.word_wr);
            nAck1   += int'(bus.r1_ack);
        end
        checkOutput("churn.extraStrobes", 32'(nStrobe),       32'd0);
        checkOutput("churn.r1_ackCount",  32'(nAck1),         32'd1);
        checkOutput("churn.addrHeld",     32'(bus.word_addr), 32'h55);
        checkOutput("churn.dataHeld",     32'(bus.word_data), 32'h11);
        checkOutput("churn.errSticky",    32'(bus.timeout_err), 32'd1);

        // ---------- contention from reset, both requests held ----------
        driveIdle();
        reset_l = 1'b0;
        bus.r0_req  = 1'b1;
        bus.r0_addr = 26'h0000010;
        bus.r1_req  = 1'b1;
        bus.r1_addr = 26'h0000020;
        bus.word_q  = 8'hC3;
        tick();
        checkOutput("contend.errCleared", 32'(bus.timeout_err), 32'd0);
        reset_l = 1'b1;
        // Grants on cycles 1,4,7,10 alternate r0,r1,r0,r1; acks two cycles after each.
        strobeMask = 13'b0_0100_1001_0010;
        addr10Mask = 13'b0_0000_1000_0010;
        ack0Mask   = 13'b0_0010_0000_1000;
        ack1Mask   = 13'b1_0000_0100_0000;
        for (int c = 1; c <= 12; c++) begin
            tick();
            checkOutput($sformatf("contend.c%0d.word_rd", c), 32'(bus.word_rd), 32'(strobeMask[c]));
            checkOutput($sformatf("contend.c%0d.r0_ack", c),  32'(bus.r0_ack),  32'(ack0Mask[c]));
            checkOutput($sformatf("contend.c%0d.r1_ack", c),  32'(bus.r1_ack),  32'(ack1Mask[c]));
            if (strobeMask[c]) begin
                checkOutput($sformatf("contend.c%0d.word_addr", c), 32'(bus.word_addr),
                            addr10Mask[c] ? 32'h10 : 32'h20);
            end
        end
        bus.r0_req = 1'b0;
        bus.r1_req = 1'b0;
        checkOutput("contend.r0_rdata", 32'(bus.r0_rdata), 32'hC3);
        checkOutput("contend.r1_rdata", 32'(bus.r1_rdata), 32'hC3);

        // ---------- reset asserted mid-WAIT ----------
        bus.r0_addr = 26'h0000077;
        bus.r0_req  = 1'b1;
        bus.word_q  = 8'h00;
        tick();
        checkOutput("midReset.strobe", 32'(bus.word_rd), 32'd1);
        bus.word_busy = 1'b1;
        repeat (3) tick();
        reset_l    = 1'b0;
        bus.r0_req = 1'b0;
        #1;
        checkOutput("midReset.word_rd",   32'(bus.word_rd),   32'd0);
        checkOutput("midReset.word_addr", 32'(bus.word_addr), 32'd0);
        checkOutput("midReset.word_data", 32'(bus.word_data), 32'd0);
        checkOutput("midReset.r0_ack",    32'(bus.r0_ack),    32'd0);
        checkOutput("midReset.r1_ack",    32'(bus.r1_ack),    32'd0);
        checkOutput("midReset.r0_rdata",  32'(bus.r0_rdata),  32'd0);
        checkOutput("midReset.r1_rdata",  32'(bus.r1_rdata),  32'd0);
        repeat (2) tick();
        reset_l       = 1'b1;
        bus.word_busy = 1'b0;
        nStrobe = 0;
        nAck0   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            nStrobe += int'(bus.word_rd) + int'(bus.word_wr);
            nAck0   += int'(bus.r0_ack) + int'(bus.r1_ack);
        end
        checkOutput("midReset.strobesAfter", 32'(nStrobe), 32'd0);
        checkOutput("midReset.acksAfter",    32'(nAck0),   32'd0);
        // A fresh request is serviced normally.
        bus.r1_req  = 1'b1;
        bus.r1_we   = 1'b0;
        bus.r1_addr = 26'h0000099;
        bus.word_q  = 8'h3C;
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (bus.r1_ack !== 1'b1 && cycles < 20);
        bus.r1_req = 1'b0;
        checkOutput("midReset.nextLatency", 32'(cycles),        32'd3);
        checkOutput("midReset.nextAddr",    32'(bus.word_addr), 32'h99);
        checkOutput("midReset.nextRdata",   32'(bus.r1_rdata),  32'h3C);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
